// File: rtl/msl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// msl_pkg : shared state encodings, parity modes and counter sizing for MSL
// Rev 1.0
// ----------------------------------------------------------------------------
package msl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RECV  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } msl_state_e;

  localparam int c_PAR_NONE = 0;
  localparam int c_PAR_EVEN = 1;
  localparam int c_PAR_ODD  = 2;

  // Wide enough to hold the largest tick threshold plus one saturation step.
  function automatic int msl_cnt_width(input int seg_max, input int gap_ticks,
                                       input int stop_ticks);
    int m;
    m = seg_max;
    if (gap_ticks > m)  m = gap_ticks;
    if (stop_ticks > m) m = stop_ticks;
    return $clog2(m + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/msl_tick_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// msl_tick_gen : one-clock sample strobe every P_TICK_DIV clocks plus a toggle
// Rev 1.0
// ----------------------------------------------------------------------------
module msl_tick_gen #(
  parameter int P_TICK_DIV = 50_000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick_stb,
  output logic o_tick
);

  localparam int c_CW = $clog2(P_TICK_DIV);

  logic [c_CW-1:0] r_cnt;
  logic            r_tgl;
  logic            w_term;

  assign w_term     = (r_cnt == c_CW'(P_TICK_DIV - 1));
  assign o_tick_stb = w_term;
  assign o_tick     = r_tgl;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_tgl <= 1'b0;
    end else if (w_term) begin
      r_cnt <= '0;
      r_tgl <= ~r_tgl;
    end else begin
      r_cnt <= r_cnt + c_CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/msl_frame_receiver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// msl_frame_receiver : single-wire MSL slave, bit value encoded as segment length
// Rev 1.0
// ----------------------------------------------------------------------------
module msl_frame_receiver
  import msl_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_TICK_DIV   = 50_000,
  parameter int P_START_MIN  = 8,
  parameter int P_SEG_MIN    = 2,
  parameter int P_ONE_MIN    = 7,
  parameter int P_SEG_MAX    = 22,
  parameter int P_STOP_TICKS = 10,
  parameter int P_GAP_TICKS  = 12,
  parameter int P_PARITY     = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_msl_sda,
  output logic [P_DATA_WIDTH-1:0] o_data,
  output logic                    o_valid,
  output logic                    o_frame_err,
  output logic                    o_parity_err,
  output logic                    o_busy,
  output logic                    o_tick
);

  localparam int c_CW    = msl_cnt_width(P_SEG_MAX, P_GAP_TICKS, P_STOP_TICKS);
  localparam int c_NBITS = P_DATA_WIDTH + ((P_PARITY != c_PAR_NONE) ? 1 : 0);
  localparam logic [c_CW-1:0] c_LEN_SAT = c_CW'(P_SEG_MAX + 1);
  localparam logic [c_CW-1:0] c_GAP_SAT = c_CW'(P_GAP_TICKS);

  msl_state_e r_state, w_state_next;

  logic                    r_sync1, r_sync2, r_last;
  logic [c_CW-1:0]         r_len, r_gap;
  logic [5:0]              r_bitcnt;
  logic [c_NBITS-1:0]      r_shift;
  logic [P_DATA_WIDTH-1:0] r_data;
  logic                    r_valid, r_ferr, r_perr;

  logic                    w_tick, w_edge, w_bit, w_par_ok;
  logic [c_CW-1:0]         w_len_next, w_gap_next;
  logic [c_NBITS-1:0]      w_shift_next;
  logic [P_DATA_WIDTH-1:0] w_payload;
  logic                    w_shift_en, w_bits_clr, w_gap_clr;
  logic                    w_valid_nx, w_ferr_nx, w_perr_nx;

  msl_tick_gen #(
    .P_TICK_DIV (P_TICK_DIV)
  ) u_tick_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .o_tick_stb (w_tick),
    .o_tick     (o_tick)
  );

  assign w_edge     = (r_sync2 != r_last);
  assign w_len_next = w_edge ? c_CW'(1)
                    : ((r_len < c_LEN_SAT) ? r_len + c_CW'(1) : r_len);
  assign w_gap_next = !r_sync2 ? '0
                    : ((r_gap < c_GAP_SAT) ? r_gap + c_CW'(1) : r_gap);
  assign w_bit      = (int'(r_len) >= P_ONE_MIN);
  assign w_payload  = r_shift[c_NBITS-1 -: P_DATA_WIDTH];
  assign w_par_ok   = (P_PARITY == c_PAR_ODD)  ? (^r_shift)
                    : (P_PARITY == c_PAR_EVEN) ? ~(^r_shift) : 1'b1;

  always_comb begin
    w_shift_next    = r_shift << 1;
    w_shift_next[0] = w_bit;
  end

  // Next-state and strobe decode; every decision is gated to tick cycles.
  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_bits_clr   = 1'b0;
    w_gap_clr    = 1'b0;
    w_valid_nx   = 1'b0;
    w_ferr_nx    = 1'b0;
    w_perr_nx    = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!r_sync2) w_state_next = ST_START;
        end
        ST_START: begin
          if (w_edge) begin
            if (int'(r_len) >= P_START_MIN) begin
              w_state_next = ST_RECV;
              w_bits_clr   = 1'b1;
            end else begin
              w_state_next = ST_IDLE;
            end
          end else if (int'(w_len_next) > P_SEG_MAX) begin
            w_ferr_nx    = 1'b1;
            w_gap_clr    = 1'b1;
            w_state_next = ST_GAP;
          end
        end
        ST_RECV: begin
          if (w_edge) begin
            if (int'(r_len) < P_SEG_MIN) begin
              w_ferr_nx    = 1'b1;
              w_gap_clr    = 1'b1;
              w_state_next = ST_GAP;
            end else begin
              w_shift_en = 1'b1;
              if (int'(r_bitcnt) == c_NBITS - 1) w_state_next = ST_STOP;
            end
          end else if (int'(w_len_next) > P_SEG_MAX) begin
            w_ferr_nx    = 1'b1;
            w_gap_clr    = 1'b1;
            w_state_next = ST_GAP;
          end
        end
        ST_STOP: begin
          if (w_edge) begin
            w_ferr_nx    = 1'b1;
            w_gap_clr    = 1'b1;
            w_state_next = ST_GAP;
          end else if (int'(w_len_next) >= P_STOP_TICKS) begin
            w_valid_nx   = w_par_ok;
            w_perr_nx    = ~w_par_ok;
            w_gap_clr    = 1'b1;
            w_state_next = ST_GAP;
          end
        end
        ST_GAP: begin
          if (int'(w_gap_next) >= P_GAP_TICKS) w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Synchroniser and line-history flops reset high to match the idle line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_last  <= 1'b1;
      r_len   <= '0;
    end else begin
      r_sync1 <= i_msl_sda;
      r_sync2 <= r_sync1;
      if (w_tick) begin
        r_last <= r_sync2;
        r_len  <= w_len_next;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_gap    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_gap_clr) begin
        r_gap <= '0;
      end else if (w_tick && (r_state == ST_GAP)) begin
        r_gap <= w_gap_next;
      end
      if (w_bits_clr) begin
        r_bitcnt <= '0;
        r_shift  <= '0;
      end else if (w_shift_en) begin
        r_bitcnt <= r_bitcnt + 6'd1;
        r_shift  <= w_shift_next;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_valid <= w_valid_nx;
      r_ferr  <= w_ferr_nx;
      r_perr  <= w_perr_nx;
      if (w_valid_nx) r_data <= w_payload;
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_frame_err  = r_ferr;
  assign o_parity_err = r_perr;
  assign o_busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
